// File: rtl/dsp_tx_path_if.sv
// dsp_tx_path_if: symbol input stream and filtered I/Q output stream of the transmit path.
interface dsp_tx_path_if #(
   parameter int SYM_W = 6,
   parameter int OUT_W = 10
);
   logic [SYM_W-1:0] in_sym;
   logic in_valid;
   logic in_ready;
   logic signed [OUT_W-1:0] I_out;
   logic signed [OUT_W-1:0] Q_out;
   logic out_valid;
   modport master(output in_sym, in_valid, input in_ready, I_out, Q_out, out_valid);
   modport slave(input in_sym, in_valid, output in_ready, I_out, Q_out, out_valid);
endinterface

// File: rtl/dsp_tx_path.sv
// dsp_tx_path: QAM mapper, zero-stuffing upsampler and I/Q FIR with saturating output.
// Define DSP_TX_CAPTURE_EN to build the output capture buffer with its SPI-style read port.
module dsp_tx_path #(
   parameter int SYM_W = 6,
   parameter int UPS = 4,
   parameter int NTAPS = 8,
   parameter int COEF_W = 16,
   parameter int SHIFT = 8,
   parameter int OUT_W = 10,
   parameter int CAP_DEPTH = 64
) (
   input logic clk,
   input logic rst,
   dsp_tx_path_if.slave s,
   input logic coef_we,
   input logic [$clog2(NTAPS)-1:0] coef_addr,
   input logic signed [COEF_W-1:0] coef_data,
   output logic sat_flag,
   input logic cap_arm,
   output logic cap_done,
   input logic spi_rd,
   input logic [$clog2(CAP_DEPTH)-1:0] spi_addr,
   output logic [2*OUT_W-1:0] spi_data_out,
   output logic spi_valid
);
   localparam int HW = SYM_W / 2;
   localparam int LW = HW + 1;
   localparam int PW = $clog2(UPS);
   localparam int CW = $clog2(NTAPS);
   localparam int FW = $clog2(NTAPS + 1);
   localparam int AW = COEF_W + LW + CW + 1;
   localparam logic signed [AW-1:0] MAXV = AW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [AW-1:0] MINV = ~MAXV;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;

   logic [1:0] state_q, state_d;
   logic [PW-1:0] phase_q, phase_d, phase_inc;
   logic [FW-1:0] flush_q, flush_d;
   logic signed [LW-1:0] xi_q [NTAPS];
   logic signed [LW-1:0] xi_d [NTAPS];
   logic signed [LW-1:0] xq_q [NTAPS];
   logic signed [LW-1:0] xq_d [NTAPS];
   logic signed [COEF_W-1:0] h_q [NTAPS];
   logic signed [COEF_W-1:0] h_d [NTAPS];
   logic signed [LW-1:0] lvl_i, lvl_q;
   logic signed [AW-1:0] acc_i, acc_q, sh_i, sh_q;
   logic signed [OUT_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
   logic out_valid_q, out_valid_d, sv_q, sv_d, sat_q, sat_d;
   logic take, shift, stop, fin;

   function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [AW-1:0] a);
      return a > MAXV ? MAXV[OUT_W-1:0] : a < MINV ? MINV[OUT_W-1:0] : a[OUT_W-1:0];
   endfunction

   assign s.in_ready = state_q != FLUSH && phase_q == '0;
   assign take = s.in_valid && s.in_ready;
   assign shift = state_q != IDLE || take;
   assign stop = state_q == RUN && phase_q == '0 && !s.in_valid;
   assign fin = flush_q == FW'(NTAPS - 1);
   assign phase_inc = phase_q == PW'(UPS - 1) ? '0 : phase_q + 1'b1;
   // Level 2k-(2^HW-1) computed modulo 2^LW gives the signed odd constellation point directly.
   assign lvl_i = $signed({s.in_sym[SYM_W-1:HW], 1'b0} - LW'((1 << HW) - 1));
   assign lvl_q = $signed({s.in_sym[HW-1:0], 1'b0} - LW'((1 << HW) - 1));

   always_comb begin
      state_d = state_q == IDLE ? (take ? RUN : IDLE) :
                state_q == RUN ? (stop ? FLUSH : RUN) : (fin ? IDLE : FLUSH);
      phase_d = ((state_q == IDLE && take) || (state_q == RUN && !stop)) ? phase_inc : '0;
      flush_d = state_q == FLUSH ? flush_q + 1'b1 : '0;
   end

   always_comb begin
      xi_d = xi_q;
      xq_d = xq_q;
      h_d = h_q;
      if (shift) begin
         xi_d[0] = take ? lvl_i : '0;
         xq_d[0] = take ? lvl_q : '0;
         for (int i = 1; i < NTAPS; i++) begin
            xi_d[i] = xi_q[i-1];
            xq_d[i] = xq_q[i-1];
         end
      end
      for (int i = 0; i < NTAPS; i++)
         if (coef_we && coef_addr == CW'(i)) h_d[i] = coef_data;
   end

   always_comb begin
      acc_i = '0;
      acc_q = '0;
      for (int i = 0; i < NTAPS; i++) begin
         acc_i = acc_i + AW'(h_q[i]) * AW'(xi_q[i]);
         acc_q = acc_q + AW'(h_q[i]) * AW'(xq_q[i]);
      end
      sh_i = acc_i >>> SHIFT;
      sh_q = acc_q >>> SHIFT;
   end

   assign i_out_d = sat_fn(sh_i);
   assign q_out_d = sat_fn(sh_q);
   assign sat_d = sat_q || sh_i > MAXV || sh_i < MINV || sh_q > MAXV || sh_q < MINV;
   assign sv_d = shift;
   assign out_valid_d = sv_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         flush_q <= '0;
         i_out_q <= '0;
         q_out_q <= '0;
         out_valid_q <= 1'b0;
         sv_q <= 1'b0;
         sat_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            xi_q[i] <= '0;
            xq_q[i] <= '0;
            h_q[i] <= i == 0 ? COEF_W'(1 << SHIFT) : '0;
         end
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         flush_q <= flush_d;
         i_out_q <= i_out_d;
         q_out_q <= q_out_d;
         out_valid_q <= out_valid_d;
         sv_q <= sv_d;
         sat_q <= sat_d;
         xi_q <= xi_d;
         xq_q <= xq_d;
         h_q <= h_d;
      end

   assign s.I_out = i_out_q;
   assign s.Q_out = q_out_q;
   assign s.out_valid = out_valid_q;
   assign sat_flag = sat_q;

`ifdef DSP_TX_CAPTURE_EN
   localparam int PA = $clog2(CAP_DEPTH);
   logic [2*OUT_W-1:0] mem [CAP_DEPTH];
   logic [PA-1:0] ptr_q, ptr_d;
   logic act_q, act_d, done_q, done_d, spv_q, spv_d, cap_we, last;
   logic [2*OUT_W-1:0] spd_q, spd_d;

   // An arm pulse wins over a sample on the same cycle; capture starts with the next valid sample.
   assign cap_we = act_q && !cap_arm && out_valid_q;
   assign last = cap_we && ptr_q == PA'(CAP_DEPTH - 1);

   always_comb begin
      ptr_d = cap_arm ? '0 : ptr_q + PA'(cap_we);
      act_d = cap_arm || (act_q && !last);
      done_d = !cap_arm && (done_q || last);
      spd_d = spi_rd ? mem[spi_addr] : spd_q;
      spv_d = spi_rd;
   end

   always_ff @(posedge clk)
      if (cap_we) mem[ptr_q] <= {i_out_q, q_out_q};

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ptr_q <= '0;
         act_q <= 1'b0;
         done_q <= 1'b0;
         spd_q <= '0;
         spv_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         act_q <= act_d;
         done_q <= done_d;
         spd_q <= spd_d;
         spv_q <= spv_d;
      end

   assign cap_done = done_q;
   assign spi_data_out = spd_q;
   assign spi_valid = spv_q;
`else
   logic unused_cap;
   assign unused_cap = ^{cap_arm, spi_rd, spi_addr};
   assign cap_done = 1'b0;
   assign spi_data_out = '0;
   assign spi_valid = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_tx_path.sv
// tb_dsp_tx_path: random and directed stimulus checked every cycle against a behavioural transmit-path model.
module tb_dsp_tx_path;
`ifdef DSP_TX_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dsp_tx_path_if #(.SYM_W(6), .OUT_W(10)) bus();
   logic coef_we, cap_arm, cap_done, spi_rd, spi_valid, sat_flag;
   logic [2:0] coef_addr;
   logic signed [15:0] coef_data;
   logic [5:0] spi_addr;
   logic [19:0] spi_data_out;

   dsp_tx_path dut (
      .clk(clk), .rst(rst), .s(bus), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .sat_flag(sat_flag), .cap_arm(cap_arm), .cap_done(cap_done),
      .spi_rd(spi_rd), .spi_addr(spi_addr), .spi_data_out(spi_data_out), .spi_valid(spi_valid)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int satv(input int a, output bit o);
      o = a > 511 || a < -512;
      return o ? (a > 0 ? 511 : -512) : a;
   endfunction

   // Model: the upsampled sample stream as a queue, convolved with the coefficient array.
   int hi_i[$], hi_q[$];
   int m_h[8];
   int m_mode, m_ph, m_fl;
   bit m_shift;
   int e_i, e_q;
   bit e_v, e_sat;
   logic [19:0] cmem[64];
   int cp;
   bit cact, cdone, e_spv;
   logic [19:0] e_spd;

   always @(posedge clk or posedge rst) begin
      int ai, aq, li, lq;
      bit oi, oq, take;
      if (rst) begin
         hi_i = {};
         hi_q = {};
         for (int k = 0; k < 8; k++) begin
            hi_i.push_back(0);
            hi_q.push_back(0);
            m_h[k] = k == 0 ? 256 : 0;
         end
         m_mode = 0; m_ph = 0; m_fl = 0; m_shift = 0;
         e_i = 0; e_q = 0; e_v = 0; e_sat = 0;
         cp = 0; cact = 0; cdone = 0; e_spv = 0; e_spd = '0;
      end else begin
         ai = 0;
         aq = 0;
         for (int k = 0; k < 8; k++) begin
            ai += m_h[k] * hi_i[k];
            aq += m_h[k] * hi_q[k];
         end
         ai = ai >>> 8;
         aq = aq >>> 8;
`ifdef DSP_TX_CAPTURE_EN
         e_spv = spi_rd;
         if (spi_rd) e_spd = cmem[spi_addr];
         if (cap_arm) begin
            cp = 0; cact = 1; cdone = 0;
         end else if (cact && e_v) begin
            cmem[cp] = {e_i[9:0], e_q[9:0]};
            cp++;
            if (cp == 64) begin cact = 0; cdone = 1; end
         end
`endif
         e_i = satv(ai, oi);
         e_q = satv(aq, oq);
         e_sat = e_sat | oi | oq;
         e_v = m_shift;
         if (coef_we) m_h[coef_addr] = coef_data;
         take = bus.in_valid && m_mode != 2 && m_ph == 0;
         li = take ? 2 * int'(bus.in_sym[5:3]) - 7 : 0;
         lq = take ? 2 * int'(bus.in_sym[2:0]) - 7 : 0;
         m_shift = m_mode != 0 || take;
         if (m_shift) begin
            hi_i.push_front(li); void'(hi_i.pop_back());
            hi_q.push_front(lq); void'(hi_q.pop_back());
         end
         if (m_mode == 0) begin
            if (take) begin m_mode = 1; m_ph = 1; end
         end else if (m_mode == 1) begin
            if (m_ph == 0 && !bus.in_valid) begin m_mode = 2; m_fl = 0; end
            else m_ph = (m_ph + 1) % 4;
         end else begin
            m_fl++;
            if (m_fl == 8) m_mode = 0;
         end
      end
   end

   always @(negedge clk) if (!rst) begin
      chk("in_ready", bus.in_ready, (m_mode != 2 && m_ph == 0));
      chk("out_valid", bus.out_valid, e_v);
      chk("I_out", bus.I_out, e_i);
      chk("Q_out", bus.Q_out, e_q);
      chk("sat_flag", sat_flag, e_sat);
      chk("cap_done", cap_done, cdone);
      chk("spi_valid", spi_valid, e_spv);
      chk("spi_data", spi_data_out, e_spd);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load_coefs(input int h0, input int hr);
      for (int k = 0; k < 8; k++) begin
         coef_we = 1'b1; coef_addr = 3'(k); coef_data = 16'(k == 0 ? h0 : hr);
         tick();
      end
      coef_we = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_sym = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      cap_arm = 1'b0; spi_rd = 1'b0; spi_addr = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_I", bus.I_out, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_sat", sat_flag, 0);

      bus.in_valid = 1'b1; bus.in_sym = 6'b111000;
      tick();
      bus.in_valid = 1'b0;
      chk("ready_ph1", bus.in_ready, 0);
      tick();
      chk("single_I", bus.I_out, 7);
      chk("single_Q", bus.Q_out, -7);
      chk("single_valid", bus.out_valid, 1);
      chk("ready_ph2", bus.in_ready, 0);
      tick();
      chk("zero1_I", bus.I_out, 0);
      chk("ready_ph3", bus.in_ready, 0);
      repeat (14) tick();
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_ready", bus.in_ready, 1);

      load_coefs(256, 256);
      bus.in_valid = 1'b1; bus.in_sym = 6'b111111;
      repeat (20) tick();
      chk("steady_I", bus.I_out, 14);
      chk("steady_Q", bus.Q_out, 14);
      chk("steady_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      repeat (20) tick();
      chk("flush_I", bus.I_out, 0);
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_ready", bus.in_ready, 1);

      pulse_rst();
      cap_arm = 1'b1;
      tick();
      cap_arm = 1'b0;
      bus.in_valid = 1'b1; bus.in_sym = 6'b111000;
      repeat (100) tick();
      bus.in_valid = 1'b0;
      repeat (20) tick();
      chk("cap_done_lit", cap_done, CAP);
      spi_rd = 1'b1; spi_addr = '0;
      tick();
      spi_rd = 1'b0;
      chk("spi_valid_lit", spi_valid, CAP);
      chk("spi_data_lit", spi_data_out, CAP ? 20'h01FF9 : 20'h0);
      tick();

      load_coefs(32767, 0);
      bus.in_valid = 1'b1; bus.in_sym = 6'b111000;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("sat_I", bus.I_out, 511);
      chk("sat_Q", bus.Q_out, -512);
      chk("sat_set", sat_flag, 1);
      repeat (20) tick();
      chk("sat_sticky", sat_flag, 1);

      bus.in_valid = 1'b1; bus.in_sym = 6'b111000;
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("arst_I", bus.I_out, 0);
      chk("arst_Q", bus.Q_out, 0);
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_sat", sat_flag, 0);
      chk("arst_spi", spi_data_out, 0);
      bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("arst_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1; bus.in_sym = 6'b000111;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("pass_I", bus.I_out, -7);
      chk("pass_Q", bus.Q_out, 7);

      for (int c = 0; c < 3000; c++) begin
         bus.in_valid = ((c / 50) % 3 != 2) && $urandom_range(0, 15) != 0;
         bus.in_sym = 6'($urandom);
         coef_we = $urandom_range(0, 19) == 0;
         coef_addr = 3'($urandom);
         coef_data = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($signed($urandom_range(0, 1200)) - 600);
         cap_arm = $urandom_range(0, 299) == 0;
         spi_rd = $urandom_range(0, 3) == 0;
         spi_addr = 6'($urandom);
         tick();
      end
      bus.in_valid = 1'b0; coef_we = 1'b0; cap_arm = 1'b0; spi_rd = 1'b0;
      repeat (20) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
